// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 (optionally 8E1) UART receive path, serial line in, parallel bytes out.
//   Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit and o_parity_error).
//   Ports:
//     i_clk            system clock, all logic on posedge
//     i_rst_n          asynchronous active-low reset
//     i_rx             serial line, idle high, asynchronous to i_clk
//     o_rx_data        last good byte, held until the next good frame
//     o_rx_valid       1-cycle pulse when o_rx_data is updated
//     o_framing_error  1-cycle pulse when the stop bit is sampled low
//     o_busy           high in every state except IDLE
//     o_parity_error   1-cycle pulse on a parity mismatch (parity build only)
module uart_receiver #(
  parameter int CLOCKS_PER_BIT = 5000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_framing_error,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_error,
`endif
  output logic       o_busy
);
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif
  state_t          r_state, w_next;
  logic            r_meta, r_rx_s;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_shift, r_rx_data;
  logic            r_rx_valid, r_ferr;
  logic            w_half, w_full, w_stop_smp, w_good, w_ferr, w_par_bad;
`ifdef UART_RX_PARITY_EN
  logic            r_par, r_perr;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_half = r_cnt == HALF;
    w_full = r_cnt == LAST;
    w_next = r_state;
    case (r_state)
      IDLE:   if (!r_rx_s) w_next = START;
      START:  if (w_half) w_next = r_rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:   if (w_full && r_bit_idx == 3'd7) w_next = PARITY;
      PARITY: if (w_full) w_next = STOP;
`else
      DATA:   if (w_full && r_bit_idx == 3'd7) w_next = STOP;
`endif
      STOP:   if (w_full) w_next = r_rx_s ? IDLE : BRK;
      BRK:    if (r_rx_s) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_busy     = r_state != IDLE;
    w_stop_smp = r_state == STOP && w_full;
`ifdef UART_RX_PARITY_EN
    w_par_bad  = ^{r_shift, r_par};
`else
    w_par_bad  = 1'b0;
`endif
    // a low stop bit outranks a parity mismatch
    w_ferr     = w_stop_smp && !r_rx_s;
    w_good     = w_stop_smp && r_rx_s && !w_par_bad;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_meta     <= 1'b1;
      r_rx_s     <= 1'b1;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
      r_perr     <= 1'b0;
`endif
    end else begin
      r_meta     <= i_rx;
      r_rx_s     <= r_meta;
      // counter restarts on every state change and at each bit boundary
      r_cnt      <= (w_next != r_state || w_full || r_state == IDLE || r_state == BRK) ? '0 : r_cnt + CW'(1);
      if (r_state == START) r_bit_idx <= '0;
      if (r_state == DATA && w_full) begin
        r_shift   <= {r_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_good) r_rx_data <= r_shift;
      r_rx_valid <= w_good;
      r_ferr     <= w_ferr;
`ifdef UART_RX_PARITY_EN
      if (r_state == PARITY && w_full) r_par <= r_rx_s;
      r_perr     <= w_stop_smp && r_rx_s && w_par_bad;
`endif
    end

  always_comb begin
    o_rx_data       = r_rx_data;
    o_rx_valid      = r_rx_valid;
    o_framing_error = r_ferr;
`ifdef UART_RX_PARITY_EN
    o_parity_error  = r_perr;
`endif
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed self-checking bench for uart_receiver at CLOCKS_PER_BIT=16.
module tb_uart_receiver;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 3 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, ferr, busy, perr;
  int         checks = 0, errors = 0;
  int         cyc = 0, valid_cyc = 0, fall_cyc = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0, bad_pulse = 0;
  int         v0, f0;
  logic       prev_pulse = 1'b0;
  logic [7:0] rxq[$];

  uart_receiver #(.CLOCKS_PER_BIT(CPB)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_rx(rx),
    .o_rx_data(rx_data),
    .o_rx_valid(rx_valid),
    .o_framing_error(ferr),
`ifdef UART_RX_PARITY_EN
    .o_parity_error(perr),
`endif
    .o_busy(busy)
  );
`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      rxq.push_back(rx_data);
      n_valid++;
      valid_cyc = cyc;
    end
    if (ferr) n_ferr++;
    if (perr) n_perr++;
    if ((rx_valid && ferr) || (rx_valid && perr) || (ferr && perr) || ((rx_valid || ferr || perr) && prev_pulse))
      bad_pulse++;
    prev_pulse = rx_valid || ferr || perr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop, input int stop_len, input logic bad_par);
    fall_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (stop_len) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b2b [3];
    logic [7:0] pb;
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55;
    pb = 8'h12;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", ferr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid_cnt", n_valid, 0);

    send(8'hA5, 1'b1, CPB, 1'b0);
    repeat (10) @(negedge clk);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_pulses", n_valid, 1);
    chk("a5_latency", valid_cyc - fall_cyc, LAT);

    v0 = n_valid;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch_busy_start", busy, 1'b1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_idle", busy, 1'b0);
    chk("glitch_no_valid", n_valid, v0);
    chk("glitch_no_ferr", n_ferr, f0);

    send(8'h3C, 1'b0, CPB, 1'b0);
    repeat (100) @(negedge clk);
    chk("brk_ferr_once", n_ferr, f0 + 1);
    chk("brk_no_valid", n_valid, v0);
    chk("brk_data_kept", rx_data, 8'hA5);
    chk("brk_busy", busy, 1'b1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("brk_release_idle", busy, 1'b0);
    send(8'h81, 1'b1, CPB, 1'b0);
    repeat (10) @(negedge clk);
    chk("after_brk_data", rx_data, 8'h81);
    chk("after_brk_valid", n_valid, v0 + 1);

    for (int s = CPB - 1; s <= CPB + 1; s++) begin
      rxq.delete();
      for (int k = 0; k < 3; k++) send(b2b[k], 1'b1, s, 1'b0);
      repeat (20) @(negedge clk);
      chk($sformatf("b2b%0d_count", s), rxq.size(), 3);
      for (int k = 0; k < 3; k++) chk($sformatf("b2b%0d_byte%0d", s, k), rxq[k], b2b[k]);
    end

    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = pb[i];
      repeat (CPB) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_data", rx_data, 8'h00);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rxq.delete();
    send(8'h34, 1'b1, CPB, 1'b0);
    repeat (20) @(negedge clk);
    chk("midrst_count", rxq.size(), 1);
    chk("midrst_byte", rxq[0], 8'h34);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid;
    f0 = n_perr;
    send(8'h07, 1'b1, CPB, 1'b1);
    repeat (10) @(negedge clk);
    chk("par_err_pulse", n_perr, f0 + 1);
    chk("par_no_valid", n_valid, v0);
    chk("par_data_kept", rx_data, 8'h34);
`endif

    chk("pulse_exclusive", bad_pulse, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
